vm1_bus_arbiter: RTL
====================

VM1_BUS_ARBITER -- requirements
Module: vm1_bus_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 4: number of vectored interrupt channels, 1..16.
REQ-002 SHALL have parameter EDGE_MASK, width NCH, default all 0: bit i=1 makes channel i edge-triggered; 0 makes it level-triggered.
REQ-003 SHALL have parameter INIT_LEN, width 8, default 10: INIT pulse length in ce cycles, 1..255.
REQ-004 SHALL have ports: clk  in  1  system clock.
REQ-005 SHALL have ports: reset_n  in  1  synchronous active-low reset, sampled on posedge clk independent of ce.
REQ-006 SHALL have ports: ce  in  1  clock enable gating all non-reset state updates.
REQ-007 SHALL have ports: irq_i  in  NCH  channel requests; irq_en_i  in  NCH  per-channel enables; irq_mask_i  in  1  global mask (PSW bit 7).
REQ-008 SHALL have ports: vec_i  in  16*NCH  channel vectors, channel i at bits [16i+15:16i].
REQ-009 SHALL have ports: virq_o  out  1  request to CPU; iako_i  in  1  CPU interrupt acknowledge; vector_o  out  16  vector data; rply_o  out  1  reply to IAKO.
REQ-010 SHALL have ports: dmr_i  in  1  DMA request; dmgo_o  out  1  DMA grant offer; sack_i  in  1  DMA active; bus_hold_o  out  1  CPU bus stalled.
REQ-011 SHALL have ports: init_req_i  in  1  INIT request pulse; init_o  out  1  peripheral INIT.
REQ-012 SHALL have ports: ack_ch_o  out  4  index of last acknowledged channel.

Function
REQ-013 Pending vector SHALL be: level channel i pending = irq_i[i]; edge channel i pending = flop set on irq_i 0->1 (sampled at ce), cleared when channel i is acknowledged.
REQ-014 Eligible = pending & irq_en_i, all zeroed while irq_mask_i=1 or init_o=1.
REQ-015 virq_o SHALL be registered, = |eligible, forced 0 in states VEC and DMA_*.
REQ-016 Priority SHALL be fixed, lowest index highest.
REQ-017 FSM states: IDLE, VEC, WAIT_DROP, DMA_OFFER, DMA_ACTIVE; all transitions only on ce.
REQ-018 IDLE: dmr_i=1 -> DMA_OFFER (DMA beats interrupts when simultaneous); else iako_i rising edge with eligible!=0 -> VEC, latching winner into ack_ch_o and its vector into vector_o; else iako_i rising edge with eligible=0 -> WAIT_DROP, no reply (upstream timeout flags bus error).
REQ-019 VEC: rply_o=1 beginning the ce cycle after the IAKO edge (latency 1 ce cycle); the acknowledged edge flop clears on VEC entry; stays in VEC until iako_i=0, then IDLE with rply_o=0 in the same update.
REQ-020 WAIT_DROP: rply_o=0; iako_i=0 -> IDLE.
REQ-021 vector_o SHALL hold its latched value until the next acknowledge; a request change during VEC SHALL NOT alter vector_o or ack_ch_o.
REQ-022 DMA_OFFER: dmgo_o=1; sack_i=1 -> DMA_ACTIVE with dmgo_o=0; dmr_i=0 with sack_i=0 -> IDLE (request withdrawn).
REQ-023 DMA_ACTIVE: bus_hold_o=1; iako_i edges ignored; sack_i=0 -> IDLE.
REQ-024 init_req_i=1 at ce SHALL load counter with INIT_LEN; counter decrements each ce while nonzero; init_o = (counter!=0); retrigger while running reloads INIT_LEN.
REQ-025 init_req_i SHALL clear all edge flops and force FSM to IDLE (all handshake outputs 0) in the same update, including mid-VEC or mid-DMA.
REQ-026 Edge event arriving in the same ce cycle as acknowledge of that channel SHALL remain pending (set beats clear).

Reset
REQ-027 reset_n=0 SHALL yield next clk: FSM IDLE, edge flops 0, virq_o=0, rply_o=0, dmgo_o=0, bus_hold_o=0, vector_o=0, ack_ch_o=0, init counter 0, init_o=0, iako/irq edge-detect history 0.

Verification
REQ-028 Channels 1 and 3 level high, enables all 1, mask 0; raise iako_i -> next ce rply_o=1, vector_o=vec_i[31:16], ack_ch_o=1; drop iako_i -> rply_o=0.
REQ-029 Edge channel 0 pulsed one cycle, then iako cycle -> vector ch0 returned, virq_o=0 afterwards; pulse during VEC of ch0 -> still pending, second ack succeeds.
REQ-030 dmr_i and iako_i rise same ce -> dmgo_o=1, rply_o=0; sack_i=1 -> dmgo_o=0, bus_hold_o=1; sack_i=0 -> IDLE, then iako serviced.
REQ-031 init_req_i pulse with INIT_LEN=10 -> init_o high exactly 10 ce cycles; second pulse at cycle 5 -> init_o high 15 total; virq_o=0 throughout.
REQ-032 irq_mask_i=1 with pending requests, iako_i raised -> WAIT_DROP, rply_o stays 0; reset_n=0 mid-VEC -> all outputs 0 next clk.

Source files
------------

// File: rtl/vm1_bus_arbiter.sv
// ---------------------------------------------------------------------------
// vm1_bus_arbiter
//
// Purpose:
//   Bus-side arbiter for a VM1-style CPU. It collects vectored interrupt
//   requests from NCH channels (each level- or edge-triggered), answers the
//   CPU interrupt-acknowledge (IAKO) handshake with the winning channel's
//   vector, arbitrates DMA requests ahead of interrupts, and generates a
//   stretched peripheral INIT pulse.
//
// Ports:
//   clk         in   1        system clock
//   reset_n     in   1        synchronous active-low reset (ignores ce)
//   ce          in   1        clock enable for every non-reset update
//   irq_i       in   NCH      channel interrupt requests
//   irq_en_i    in   NCH      per-channel interrupt enables
//   irq_mask_i  in   1        global interrupt mask (PSW bit 7)
//   vec_i       in   16*NCH   channel vectors, channel i at [16i+15:16i]
//   virq_o      out  1        interrupt request to the CPU
//   iako_i      in   1        CPU interrupt acknowledge
//   vector_o    out  16       vector returned on acknowledge
//   rply_o      out  1        reply to IAKO
//   dmr_i       in   1        DMA request
//   dmgo_o      out  1        DMA grant offer
//   sack_i      in   1        DMA master active
//   bus_hold_o  out  1        CPU bus stalled by DMA
//   init_req_i  in   1        INIT request pulse
//   init_o      out  1        peripheral INIT
//   ack_ch_o    out  4        index of the last acknowledged channel
// ---------------------------------------------------------------------------
module vm1_bus_arbiter #(
    parameter int             NCH       = 4,
    parameter logic [NCH-1:0] EDGE_MASK = '0,
    parameter logic [7:0]     INIT_LEN  = 8'd10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce,
    input  logic [NCH-1:0]    irq_i,
    input  logic [NCH-1:0]    irq_en_i,
    input  logic              irq_mask_i,
    input  logic [16*NCH-1:0] vec_i,
    output logic              virq_o,
    input  logic              iako_i,
    output logic [15:0]       vector_o,
    output logic              rply_o,
    input  logic              dmr_i,
    output logic              dmgo_o,
    input  logic              sack_i,
    output logic              bus_hold_o,
    input  logic              init_req_i,
    output logic              init_o,
    output logic [3:0]        ack_ch_o
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_VEC        = 3'd1,
        ST_WAIT_DROP  = 3'd2,
        ST_DMA_OFFER  = 3'd3,
        ST_DMA_ACTIVE = 3'd4
    } state_t;

    state_t           r_state;
    logic [NCH-1:0]   r_edge;
    logic [NCH-1:0]   r_irq_d;
    logic             r_iako_d;
    logic [7:0]       r_init_cnt;
    logic             r_virq;
    logic             r_rply;
    logic             r_dmgo;
    logic             r_bus_hold;
    logic [15:0]      r_vector;
    logic [3:0]       r_ack_ch;

    logic [NCH-1:0]   w_irq_rise;
    logic [NCH-1:0]   w_pending;
    logic [NCH-1:0]   w_eligible;
    logic             w_any;
    logic             w_init_active;
    logic             w_iako_rise;
    logic             w_ack_fire;
    logic [3:0]       w_win_idx;
    logic [NCH-1:0]   w_win_onehot;
    logic [15:0]      w_win_vec;
    logic [NCH-1:0]   w_edge_clr;
    logic [NCH-1:0]   w_edge_nxt;

    // ---------------- request qualification ----------------
    assign w_irq_rise    = irq_i & ~r_irq_d;
    assign w_iako_rise   = iako_i & ~r_iako_d;
    assign w_init_active = (r_init_cnt != 8'd0);

    // Edge channels are represented by their sticky flop, level channels by the raw input.
    assign w_pending  = (r_edge & EDGE_MASK) | (irq_i & ~EDGE_MASK);
    assign w_eligible = (irq_mask_i || w_init_active) ? '0 : (w_pending & irq_en_i);
    assign w_any      = |w_eligible;

    // Fixed priority: scan from the top down so the lowest set index is the last write.
    always_comb begin
        w_win_idx    = 4'd0;
        w_win_onehot = '0;
        w_win_vec    = 16'd0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_win_idx       = 4'(i);
                w_win_onehot    = '0;
                w_win_onehot[i] = 1'b1;
                w_win_vec       = vec_i[16*i +: 16];
            end
        end
    end

    // An acknowledge is accepted only from IDLE, and only when DMA is not asking in the same update.
    assign w_ack_fire = (r_state == ST_IDLE) && !dmr_i && w_iako_rise && w_any && !init_req_i;

    // A fresh edge on the channel being acknowledged must survive the clear.
    assign w_edge_clr = w_ack_fire ? w_win_onehot : '0;
    assign w_edge_nxt = init_req_i ? '0 : (((r_edge & ~w_edge_clr) | w_irq_rise) & EDGE_MASK);

    // ---------------- registered state and outputs ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_edge     <= '0;
            r_irq_d    <= '0;
            r_iako_d   <= 1'b0;
            r_init_cnt <= 8'd0;
            r_virq     <= 1'b0;
            r_rply     <= 1'b0;
            r_dmgo     <= 1'b0;
            r_bus_hold <= 1'b0;
            r_vector   <= 16'd0;
            r_ack_ch   <= 4'd0;
        end else if (ce) begin
            r_irq_d  <= irq_i;
            r_iako_d <= iako_i;
            r_edge   <= w_edge_nxt;

            if (init_req_i) begin
                r_init_cnt <= INIT_LEN;
            end else if (w_init_active) begin
                r_init_cnt <= r_init_cnt - 8'd1;
            end

            if (init_req_i) begin
                // INIT aborts any handshake in progress; vector/ack_ch keep their last value.
                r_state    <= ST_IDLE;
                r_virq     <= 1'b0;
                r_rply     <= 1'b0;
                r_dmgo     <= 1'b0;
                r_bus_hold <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (dmr_i) begin
                            r_state <= ST_DMA_OFFER;
                            r_dmgo  <= 1'b1;
                            r_virq  <= 1'b0;
                        end else if (w_ack_fire) begin
                            r_state  <= ST_VEC;
                            r_rply   <= 1'b1;
                            r_vector <= w_win_vec;
                            r_ack_ch <= w_win_idx;
                            r_virq   <= 1'b0;
                        end else if (w_iako_rise) begin
                            // Nothing to hand out: stay silent and let the bus timeout flag it.
                            r_state <= ST_WAIT_DROP;
                            r_virq  <= w_any;
                        end else begin
                            r_virq <= w_any;
                        end
                    end
                    ST_VEC: begin
                        if (!iako_i) begin
                            r_state <= ST_IDLE;
                            r_rply  <= 1'b0;
                            r_virq  <= w_any;
                        end else begin
                            r_virq <= 1'b0;
                        end
                    end
                    ST_WAIT_DROP: begin
                        r_rply <= 1'b0;
                        r_virq <= w_any;
                        if (!iako_i) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_DMA_OFFER: begin
                        if (sack_i) begin
                            r_state    <= ST_DMA_ACTIVE;
                            r_dmgo     <= 1'b0;
                            r_bus_hold <= 1'b1;
                            r_virq     <= 1'b0;
                        end else if (!dmr_i) begin
                            r_state <= ST_IDLE;
                            r_dmgo  <= 1'b0;
                            r_virq  <= w_any;
                        end else begin
                            r_virq <= 1'b0;
                        end
                    end
                    ST_DMA_ACTIVE: begin
                        if (!sack_i) begin
                            r_state    <= ST_IDLE;
                            r_bus_hold <= 1'b0;
                            r_virq     <= w_any;
                        end else begin
                            r_virq <= 1'b0;
                        end
                    end
                    default: begin
                        r_state    <= ST_IDLE;
                        r_virq     <= 1'b0;
                        r_rply     <= 1'b0;
                        r_dmgo     <= 1'b0;
                        r_bus_hold <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign virq_o     = r_virq;
    assign rply_o     = r_rply;
    assign vector_o   = r_vector;
    assign ack_ch_o   = r_ack_ch;
    assign dmgo_o     = r_dmgo;
    assign bus_hold_o = r_bus_hold;
    assign init_o     = w_init_active;

endmodule
